// File: rtl/sram_rd_stream.sv
// sram_rd_stream: burst read sequencer for the 16x64 single-port SRAM.
// Issues consecutive reads via active-low CEN/WEN, absorbs the one-cycle
// read latency and streams the words out through a 2-entry valid/ready FIFO.
// Optional feature: define RD_STREAM_LAST_EN to add the out_last port.
module sram_rd_stream #(
  parameter int sram_bit = 64,
  parameter int addr_bit = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                start,
  input  logic [addr_bit-1:0] base_addr,
  input  logic [addr_bit:0]   len,
  output logic                busy,
  output logic                done,
  output logic                CEN,
  output logic                WEN,
  output logic [addr_bit-1:0] A,
  output logic [sram_bit-1:0] D,
  input  logic [sram_bit-1:0] Q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [sram_bit-1:0] out_data
`ifdef RD_STREAM_LAST_EN
  ,
  output logic                out_last
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [addr_bit:0] ONE = 1;

  state_t              state;
  logic [addr_bit-1:0] base_q;
  logic [addr_bit:0]   len_q;
  logic [addr_bit:0]   issued;
  logic                inflight;
  logic [sram_bit-1:0] fifo_data [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          occ;
  logic                pop;
  logic                push;
  logic                issue;
  logic                last_issue;

  assign pop        = out_valid & out_ready;
  assign push       = inflight;
  assign last_issue = (issued + ONE) == len_q;

  // CEN is decoded combinationally because a pop in the current cycle frees
  // a slot: issue restarts in the same cycle out_ready rises, with no bubble.
  assign issue = (state == ISSUE) &&
                 (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

  assign CEN       = ~issue;
  assign WEN       = 1'b1;
  assign D         = '0;
  assign A         = base_q + issued[addr_bit-1:0];
  assign busy      = (state != IDLE);
  assign out_valid = (occ != 2'd0);
  assign out_data  = fifo_data[rd_ptr];

  // Burst control: command accept, issue counting, drain and done pulse.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      inflight <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      case (state)
        IDLE: begin
          if (start && !done) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              base_q <= base_addr;
              len_q  <= len;
              issued <= '0;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            issued <= issued + ONE;
            if (last_issue) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Done lands on the edge of the final pop so it is visible in the
          // cycle after the last handshake.
          if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output FIFO; SRAM data lands at the tail one edge after a read.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int unsigned i = 0; i < 2; i++) fifo_data[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= Q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef RD_STREAM_LAST_EN
  logic fifo_last [2];
  logic inflight_last;

  assign out_last = fifo_last[rd_ptr] & out_valid;

  // Per-entry end-of-burst flag travelling alongside the read data.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inflight_last <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fifo_last[i] <= 1'b0;
    end else begin
      inflight_last <= issue & last_issue;
      if (push) fifo_last[wr_ptr] <= inflight_last;
    end
  end
`endif

endmodule
